// File: rtl/fir_seq_ctrl.sv
// Sequencing FSM for the FIR datapath: walks n over samples and k over taps, aligns MAC controls to memory latency.
// Optional abort input enabled by defining FIR_SEQ_CTRL_ABORT_EN.
module fir_seq_ctrl #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned AW_X   = 14,
   parameter int unsigned AW_H   = 6
) (
   input  logic            clk_b,
   input  logic            rst_n,
   input  logic            Start,
   input  logic [5:0]      Ile_wsp,
   input  logic [13:0]     Ile_probek,
`ifdef FIR_SEQ_CTRL_ABORT_EN
   input  logic            abort,
`endif
   output logic            Pracuje,
   output logic            DONE,
   output logic            rd_en,
   output logic [AW_X-1:0] adr_x,
   output logic [AW_H-1:0] adr_h,
   output logic            mac_clr,
   output logic            mac_en,
   output logic            mac_zero,
   output logic            wr_wyn,
   output logic [AW_X-1:0] adr_wyn
);

   localparam int unsigned CW = (AW_X > AW_H) ? AW_X : AW_H;

   typedef enum logic [2:0] {IDLE, CLR, MAC, DRAIN, WRITE, FIN} state_t;

   state_t            state, state_nx;
   logic [AW_X-1:0]   n, n_nx;
   logic [AW_H-1:0]   k, k_nx;
   logic [2:0]        dcnt, dcnt_nx;
   logic [AW_X-1:0]   p_r;
   logic [AW_H-1:0]   w_r;
   logic              start_q;
   logic              launch;
   logic              tag;
   logic              abort_hit;
   logic [RD_LAT-1:0] en_sr;
   logic [RD_LAT-1:0] zero_sr;

`ifdef FIR_SEQ_CTRL_ABORT_EN
   assign abort_hit = abort && (state != IDLE) && (state != FIN);
`else
   assign abort_hit = 1'b0;
`endif

   assign launch   = (state == IDLE) && Start && !start_q;
   assign mac_en   = en_sr[RD_LAT-1];
   assign mac_zero = zero_sr[RD_LAT-1];

   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         n       <= '0;
         k       <= '0;
         dcnt    <= '0;
         p_r     <= '0;
         w_r     <= '0;
         start_q <= 1'b0;
      end else begin
         state   <= state_nx;
         n       <= n_nx;
         k       <= k_nx;
         dcnt    <= dcnt_nx;
         start_q <= Start;
         if (launch) begin
            p_r <= AW_X'(Ile_probek);
            w_r <= AW_H'(Ile_wsp);
         end
      end
   end

   // Delay line carries the read strobe and its zero-padding tag to the memory-data cycle.
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         en_sr   <= '0;
         zero_sr <= '0;
      end else if (abort_hit) begin
         en_sr   <= '0;
         zero_sr <= '0;
      end else begin
         en_sr[0]   <= rd_en;
         zero_sr[0] <= tag;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            en_sr[i]   <= en_sr[i-1];
            zero_sr[i] <= zero_sr[i-1];
         end
      end
   end

   always_comb begin
      state_nx = state;
      n_nx     = n;
      k_nx     = k;
      dcnt_nx  = dcnt;
      Pracuje  = (state != IDLE);
      DONE     = 1'b0;
      rd_en    = 1'b0;
      adr_x    = '0;
      adr_h    = '0;
      tag      = 1'b0;
      mac_clr  = 1'b0;
      wr_wyn   = 1'b0;
      adr_wyn  = '0;

      unique case (state)
         IDLE: begin
            if (launch) begin
               if ((Ile_wsp != '0) && (Ile_probek != '0)) state_nx = CLR;
               else                                       state_nx = FIN;
            end
         end
         CLR: begin
            mac_clr  = 1'b1;
            k_nx     = '0;
            state_nx = MAC;
         end
         MAC: begin
            rd_en   = 1'b1;
            adr_h   = k;
            adr_x   = n - AW_X'(k);
            tag     = (CW'(k) > CW'(n));
            dcnt_nx = '0;
            if (k == w_r - AW_H'(1)) state_nx = DRAIN;
            else                     k_nx     = k + AW_H'(1);
         end
         DRAIN: begin
            if (dcnt == 3'(RD_LAT - 1)) state_nx = WRITE;
            else                        dcnt_nx  = dcnt + 3'd1;
         end
         WRITE: begin
            wr_wyn  = 1'b1;
            adr_wyn = n;
            if (n == p_r - AW_X'(1)) begin
               state_nx = FIN;
            end else begin
               n_nx     = n + AW_X'(1);
               state_nx = CLR;
            end
         end
         FIN: begin
            DONE     = 1'b1;
            n_nx     = '0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      if (abort_hit) begin
         state_nx = IDLE;
         n_nx     = '0;
         k_nx     = '0;
         dcnt_nx  = '0;
      end
   end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: two instances (RD_LAT 1 and 3) traced cycle by cycle against a schedule model.
// Abort scenario is compiled only when FIR_SEQ_CTRL_ABORT_EN is defined.
module tb_fir_seq_ctrl;

   logic        clk_b = 1'b0;
   logic        rst_n;
   logic        Start;
   logic [5:0]  Ile_wsp;
   logic [13:0] Ile_probek;
`ifdef FIR_SEQ_CTRL_ABORT_EN
   logic        abort;
`endif

   logic        pr_1, dn_1, rd_1, clr_1, me_1, mz_1, wr_1;
   logic [13:0] ax_1, aw_1;
   logic [5:0]  ah_1;
   logic        pr_3, dn_3, rd_3, clr_3, me_3, mz_3, wr_3;
   logic [13:0] ax_3, aw_3;
   logic [5:0]  ah_3;

   logic [40:0] obs1, obs3;
   assign obs1 = {pr_1, dn_1, rd_1, ax_1, ah_1, clr_1, me_1, mz_1, wr_1, aw_1};
   assign obs3 = {pr_3, dn_3, rd_3, ax_3, ah_3, clr_3, me_3, mz_3, wr_3, aw_3};

   int n_pass   = 0;
   int n_checks = 0;

   always #5 clk_b = ~clk_b;

   fir_seq_ctrl #(.RD_LAT(1), .AW_X(14), .AW_H(6)) dut1 (
      .clk_b(clk_b), .rst_n(rst_n), .Start(Start), .Ile_wsp(Ile_wsp), .Ile_probek(Ile_probek),
`ifdef FIR_SEQ_CTRL_ABORT_EN
      .abort(abort),
`endif
      .Pracuje(pr_1), .DONE(dn_1), .rd_en(rd_1), .adr_x(ax_1), .adr_h(ah_1), .mac_clr(clr_1),
      .mac_en(me_1), .mac_zero(mz_1), .wr_wyn(wr_1), .adr_wyn(aw_1)
   );

   fir_seq_ctrl #(.RD_LAT(3), .AW_X(14), .AW_H(6)) dut3 (
      .clk_b(clk_b), .rst_n(rst_n), .Start(Start), .Ile_wsp(Ile_wsp), .Ile_probek(Ile_probek),
`ifdef FIR_SEQ_CTRL_ABORT_EN
      .abort(abort),
`endif
      .Pracuje(pr_3), .DONE(dn_3), .rd_en(rd_3), .adr_x(ax_3), .adr_h(ah_3), .mac_clr(clr_3),
      .mac_en(me_3), .mac_zero(mz_3), .wr_wyn(wr_3), .adr_wyn(aw_3)
   );

   // Expected outputs c cycles after the launch cycle, from the per-sample schedule
   // CLR, W reads, L drain cycles, WRITE, and a final FIN cycle.
   function automatic logic [40:0] expect_out(input int w, input int p, input int l, input int c);
      logic pr, dn, rd, clr, me, mz, wr;
      logic [13:0] ax, aw;
      logic [5:0]  ah;
      int t, n, j, kk;
      pr = 0; dn = 0; rd = 0; clr = 0; me = 0; mz = 0; wr = 0;
      ax = '0; aw = '0; ah = '0;
      if (c >= 1) begin
         if (w == 0 || p == 0) begin
            if (c == 1) begin pr = 1; dn = 1; end
         end else begin
            t = w + l + 2;
            if (c <= p * t) begin
               pr = 1;
               n  = (c - 1) / t;
               j  = (c - 1) % t;
               if (j == 0) clr = 1;
               if (j >= 1 && j <= w) begin
                  rd = 1;
                  ah = 6'(j - 1);
                  ax = 14'(n - (j - 1));
               end
               kk = j - l - 1;
               if (kk >= 0 && kk < w) begin
                  me = 1;
                  mz = (kk > n);
               end
               if (j == t - 1) begin
                  wr = 1;
                  aw = 14'(n);
               end
            end else if (c == p * t + 1) begin
               pr = 1;
               dn = 1;
            end
         end
      end
      return {pr, dn, rd, ax, ah, clr, me, mz, wr, aw};
   endfunction

   function automatic int run_len(input int w, input int p, input int l);
      return (w == 0 || p == 0) ? 1 : p * (w + l + 2) + 1;
   endfunction

   task automatic launch(input int w, input int p);
      Start = 1'b0;
      @(negedge clk_b);
      @(negedge clk_b);
      Ile_wsp    = 6'(w);
      Ile_probek = 14'(p);
      Start      = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; Start = 1'b0; Ile_wsp = '0; Ile_probek = '0;
`ifdef FIR_SEQ_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      @(negedge clk_b);
      @(negedge clk_b);
      n_checks++;
      if (obs1 !== 41'd0) $display("FAIL reset_lat1 got %h want %h", obs1, 41'd0); else n_pass++;
      n_checks++;
      if (obs3 !== 41'd0) $display("FAIL reset_lat3 got %h want %h", obs3, 41'd0); else n_pass++;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_b);
         n_checks++;
         if ({obs1, obs3} !== 82'd0) $display("FAIL reset_idle got %h/%h want 0", obs1, obs3); else n_pass++;
      end
   endtask

   task automatic test_basic;
      int nc;
      launch(3, 4);
      nc = run_len(3, 4, 3) + 3;
      for (int c = 1; c <= nc; c++) begin
         @(negedge clk_b);
         n_checks++;
         if (obs1 !== expect_out(3, 4, 1, c))
            $display("FAIL basic_lat1 c=%0d got %h want %h", c, obs1, expect_out(3, 4, 1, c));
         else n_pass++;
         n_checks++;
         if (obs3 !== expect_out(3, 4, 3, c))
            $display("FAIL basic_lat3 c=%0d got %h want %h", c, obs3, expect_out(3, 4, 3, c));
         else n_pass++;
         if (c == 25) begin
            n_checks++;
            if (dn_1 !== 1'b1) $display("FAIL basic_done25 got %b want 1", dn_1); else n_pass++;
         end
      end
   endtask

   task automatic test_empty;
      launch(0, 5);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk_b);
         n_checks++;
         if (obs1 !== expect_out(0, 5, 1, c))
            $display("FAIL empty_lat1 c=%0d got %h want %h", c, obs1, expect_out(0, 5, 1, c));
         else n_pass++;
         n_checks++;
         if (obs3 !== expect_out(0, 5, 3, c))
            $display("FAIL empty_lat3 c=%0d got %h want %h", c, obs3, expect_out(0, 5, 3, c));
         else n_pass++;
      end
   endtask

   task automatic test_lat3_short;
      int nc;
      launch(2, 2);
      nc = run_len(2, 2, 3) + 2;
      for (int c = 1; c <= nc; c++) begin
         @(negedge clk_b);
         n_checks++;
         if (obs3 !== expect_out(2, 2, 3, c))
            $display("FAIL lat3_w2p2 c=%0d got %h want %h", c, obs3, expect_out(2, 2, 3, c));
         else n_pass++;
         n_checks++;
         if (obs1 !== expect_out(2, 2, 1, c))
            $display("FAIL lat1_w2p2 c=%0d got %h want %h", c, obs1, expect_out(2, 2, 1, c));
         else n_pass++;
      end
   endtask

   // Start bounced and inputs changed mid-run, then Start left high past DONE.
   task automatic test_start_ignore;
      int nc;
      launch(3, 3);
      nc = run_len(3, 3, 3) + 6;
      for (int c = 1; c <= nc; c++) begin
         @(negedge clk_b);
         n_checks++;
         if (obs1 !== expect_out(3, 3, 1, c))
            $display("FAIL start_ign_lat1 c=%0d got %h want %h", c, obs1, expect_out(3, 3, 1, c));
         else n_pass++;
         n_checks++;
         if (obs3 !== expect_out(3, 3, 3, c))
            $display("FAIL start_ign_lat3 c=%0d got %h want %h", c, obs3, expect_out(3, 3, 3, c));
         else n_pass++;
         if (c == 3) begin Ile_wsp = 6'd7; Ile_probek = 14'd9; end
         if (c == 5) Start = 1'b0;
         if (c == 8) Start = 1'b1;
      end
   endtask

   task automatic test_random;
      int w, p, nc;
      for (int r = 0; r < 10; r++) begin
         w = int'($urandom_range(0, 6));
         p = int'($urandom_range(0, 4));
         if (r == 0) w = 1;
         launch(w, p);
         nc = run_len(w, p, 3) + 2;
         for (int c = 1; c <= nc; c++) begin
            @(negedge clk_b);
            n_checks++;
            if (obs1 !== expect_out(w, p, 1, c))
               $display("FAIL rand_lat1 w=%0d p=%0d c=%0d got %h want %h", w, p, c, obs1, expect_out(w, p, 1, c));
            else n_pass++;
            n_checks++;
            if (obs3 !== expect_out(w, p, 3, c))
               $display("FAIL rand_lat3 w=%0d p=%0d c=%0d got %h want %h", w, p, c, obs3, expect_out(w, p, 3, c));
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_midrun;
      launch(4, 3);
      for (int c = 1; c <= 8; c++) @(negedge clk_b);
      rst_n = 1'b0;
      Start = 1'b0;
      #1;
      n_checks++;
      if ({obs1, obs3} !== 82'd0) $display("FAIL rst_mid_async got %h/%h want 0", obs1, obs3); else n_pass++;
      @(negedge clk_b);
      rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk_b);
         n_checks++;
         if ({obs1, obs3} !== 82'd0) $display("FAIL rst_mid_idle c=%0d got %h/%h want 0", c, obs1, obs3); else n_pass++;
      end
   endtask

`ifdef FIR_SEQ_CTRL_ABORT_EN
   task automatic test_abort;
      int ca;
      logic [40:0] e1, e3;
      ca = 15;
      launch(3, 4);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk_b);
         e1 = (c <= ca) ? expect_out(3, 4, 1, c) : 41'd0;
         e3 = (c <= ca) ? expect_out(3, 4, 3, c) : 41'd0;
         n_checks++;
         if (obs1 !== e1) $display("FAIL abort_lat1 c=%0d got %h want %h", c, obs1, e1); else n_pass++;
         n_checks++;
         if (obs3 !== e3) $display("FAIL abort_lat3 c=%0d got %h want %h", c, obs3, e3); else n_pass++;
         abort = (c == ca);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_empty;
      test_lat3_short;
      test_start_ignore;
      test_random;
      test_reset_midrun;
`ifdef FIR_SEQ_CTRL_ABORT_EN
      test_abort;
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequencing FSM for the FIR datapath.
- Consumes the control-register outputs (Start level, coefficient count, sample count) and drives the sample/coefficient memory read addresses, MAC accumulator controls and result-memory write strobe.
- Reports Pracuje (busy) and a one-cycle DONE pulse back to the control registers.
- Computes y[n] = sum over k of h[k]·x[n-k], treating x[negative] as zero.

Parameters:
- RD_LAT, 1, read latency of sample/coefficient memories in clk_b cycles (1..4).
- AW_X, 14, sample/result address width; must be ≥ width of Ile_probek.
- AW_H, 6, coefficient address width; must be ≥ width of Ile_wsp.

Ports:
- clk_b  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- Start  in  1  level from control register; rising edge launches a run
- Ile_wsp  in  6  number of coefficients (taps)
- Ile_probek  in  14  number of samples to filter
- Pracuje  out  1  high while state != IDLE
- DONE  out  1  one-cycle pulse at end of run
- rd_en  out  1  read strobe to sample and coefficient memories
- adr_x  out  AW_X  sample read address (n-k)
- adr_h  out  AW_H  coefficient read address (k)
- mac_clr  out  1  clear accumulator (one cycle per output sample)
- mac_en  out  1  accumulate product; aligned with memory data (rd_en delayed RD_LAT)
- mac_zero  out  1  with mac_en: term is zero padding, datapath adds 0
- wr_wyn  out  1  result write strobe
- adr_wyn  out  AW_X  result write address (n)

Behaviour:
- Reset: all outputs 0, state IDLE, counters n = k = 0, RD_LAT delay lines cleared.
- Start edge detect: a launch is registered Start_q = 0 and Start = 1; evaluated only in IDLE. Edges outside IDLE are ignored and are not queued.
- On launch: latch Ile_wsp → W and Ile_probek → P. Later changes to the inputs have no effect until the next run.
- States: IDLE, CLR, MAC, DRAIN, WRITE, FIN.
- IDLE → CLR on launch if W != 0 and P != 0. IDLE → FIN on launch if W == 0 or P == 0; no reads, no writes.
- CLR (1 cycle): mac_clr = 1; k = 0. → MAC.
- MAC (W cycles):
  - rd_en = 1, adr_h = k, adr_x = n-k (low AW_X bits).
  - mac_zero tag = (k > n).
  - k increments each cycle; after k == W-1 → DRAIN.
- DRAIN (RD_LAT cycles): rd_en = 0; in-flight terms arrive. mac_en and mac_zero equal rd_en and the tag delayed exactly RD_LAT cycles through the shift register.
- WRITE (1 cycle): wr_wyn = 1, adr_wyn = n.
  - If n == P-1 → FIN.
  - Else n += 1 → CLR.
- FIN (1 cycle): DONE = 1. → IDLE, n = 0.
- Cycles per output sample: W + RD_LAT + 2. Total run from launch cycle to DONE: P·(W + RD_LAT + 2) + 1.
- Pracuje: combinational from state register, 1 in every non-IDLE state including FIN.
- Boundaries:
  - W = 1: MAC lasts 1 cycle.
  - P = 16383: n reaches 16382 and terminates with no wrap.
  - Start held high across the end of a run: no relaunch. Start must return low and rise again.
  - Reset mid-run: immediate return to IDLE, outputs 0, no DONE.

Optional Feature:
- Macro FIR_SEQ_CTRL_ABORT_EN adds input port abort (1 bit).
- With the macro:
  - abort = 1 in any state other than IDLE/FIN forces the next state to IDLE.
  - rd_en, wr_wyn and the delay line are cleared in that same next cycle.
  - No DONE pulse; Pracuje drops one cycle after abort is sampled.
  - abort in IDLE or FIN is ignored.
- Without the macro: the port does not exist and runs always complete.

Test Plan:
- Reset; set W=3, P=4, RD_LAT=1; raise Start → Pracuje next cycle; DONE pulse exactly 4·6+1 = 25 cycles after the launch cycle; wr_wyn asserted 4 times with adr_wyn 0,1,2,3.
- Same run, check n=1 → adr_x sequence 1,0,3FFF (low bits); mac_zero on the delayed mac_en cycles is 0,0,1; mac_clr precedes each group.
- W=0, P=5, Start rises → FIN: DONE after 1 cycle, Pracuje high for exactly that one cycle, no rd_en/wr_wyn.
- Start pulsed again mid-run and Ile_wsp changed mid-run → run length and addresses unchanged; Start held high after DONE → no second run until low→high.
- RD_LAT=3, W=2, P=2 → mac_en lags rd_en by 3 cycles; wr_wyn only after the last mac_en; total 2·7+1 = 15 cycles.
- With FIR_SEQ_CTRL_ABORT_EN: abort in MAC of sample 2 → IDLE next cycle, no DONE, no further wr_wyn. rst_n low mid-run → all outputs 0 asynchronously.
